// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use IF hold, EX/ID jump redirect arbitration,
// EX bubble injection and saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned LOAD_STALL = 1,
  parameter int unsigned EX_FLUSH   = 2,
  parameter int unsigned PERF_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_rs1_vld,
  input  logic              id_rs2_vld,
  input  logic [4:0]        ex_rd,
  input  logic [6:0]        ex_opcode,
  input  logic              id_jmp_vld,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_pc,
  input  logic              ex_jmp_vld,
  input  logic [XLEN-1:0]   ex_jmp_addr,
  input  logic              ex_busy,
  output logic              hold_if,
  output logic              jmp_vld_if,
  output logic [XLEN-1:0]   jmp_addr_if,
  output logic              inst_vld_ex,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
);

  localparam logic [6:0] OP_LOAD = 7'b0000011;

  typedef enum logic {
    S_IDLE,
    S_LU
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        lu_cnt_q, lu_cnt_d;
  logic [2:0]        fl_cnt_q, fl_cnt_d;
  logic              hold_bub_q;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;
  logic              lu_det;
  logic              lu_hold;
  logic              jmp_bub;

  assign lu_det = (ex_opcode == OP_LOAD) && (ex_rd != 5'd0) &&
                  (((id_rs1 == ex_rd) && id_rs1_vld) || ((id_rs2 == ex_rd) && id_rs2_vld));

  // The final LU cycle masks lu_det: ID/EX still carries the load being waited on.
  always_comb begin
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    lu_hold  = 1'b0;
    if (ex_jmp_vld) begin
      state_d  = S_IDLE;
      lu_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (lu_det) begin
            lu_hold  = 1'b1;
            lu_cnt_d = 3'(LOAD_STALL - 1);
            state_d  = S_LU;
          end
        end
        S_LU: begin
          if (lu_cnt_q != '0) begin
            lu_hold  = 1'b1;
            lu_cnt_d = lu_cnt_q - 3'd1;
          end else begin
            state_d  = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    jmp_vld_if  = 1'b0;
    jmp_addr_if = '0;
    if (ex_jmp_vld) begin
      jmp_vld_if  = 1'b1;
      jmp_addr_if = ex_jmp_addr;
    end else if (id_jmp_vld) begin
      jmp_vld_if  = 1'b1;
      jmp_addr_if = id_pc + id_imm;
    end
  end

  always_comb begin
    fl_cnt_d = fl_cnt_q;
    if (ex_jmp_vld) begin
      fl_cnt_d = 3'(EX_FLUSH - 1);
    end else if (fl_cnt_q != '0) begin
      fl_cnt_d = fl_cnt_q - 3'd1;
    end
  end

  assign jmp_bub     = ex_jmp_vld || (fl_cnt_q != '0);
  assign hold_if     = lu_hold || ex_busy;
  assign inst_vld_ex = !(jmp_bub || hold_bub_q);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hold_if && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + PERF_W'(1);
    if (jmp_bub && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + PERF_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lu_cnt_q    <= '0;
      fl_cnt_q    <= '0;
      hold_bub_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lu_cnt_q    <= lu_cnt_d;
      fl_cnt_q    <= fl_cnt_d;
      hold_bub_q  <= lu_hold;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the RV32 5-stage core, sitting beside the IF/ID/EX stages. It detects load-use hazards and stalls IF for a configurable number of cycles. It arbitrates ID-resolved and EX-resolved jumps into a single redirect to IF and injects a configurable number of EX bubbles per event. It also stalls for multi-cycle EX units and keeps saturating stall/flush performance counters.

## Interface
- XLEN, 32, datapath/address width
- LOAD_STALL, 1, IF hold cycles per load-use hazard (legal 1..4)
- EX_FLUSH, 2, EX bubble cycles per EX-resolved jump (legal 1..4)
- PERF_W, 16, width of performance counters

- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs1, id_rs2  in  5 each  source registers of instruction in ID
- id_rs1_vld, id_rs2_vld  in  1 each  source actually read
- ex_rd  in  5  rd of instruction in ID/EX register
- ex_opcode  in  7  opcode of instruction in ID/EX register
- id_jmp_vld  in  1  unconditional jump decoded in ID
- id_imm, id_pc  in  XLEN each  ID jump offset and PC
- ex_jmp_vld  in  1  taken branch/jump resolved in EX
- ex_jmp_addr  in  XLEN  EX redirect target
- ex_busy  in  1  multi-cycle EX unit occupied
- hold_if  out  1  freeze PC and IF/ID register
- jmp_vld_if  out  1  redirect PC this cycle
- jmp_addr_if  out  XLEN  redirect target
- inst_vld_ex  out  1  instruction entering EX is valid (0 = bubble)
- stall_cnt  out  PERF_W  cycles with hold_if=1
- flush_cnt  out  PERF_W  cycles with a jump-induced EX bubble

## Operation
- Load-use detect: lu_det = (ex_opcode==7'b0000011) && ex_rd!=0 && ((id_rs1==ex_rd && id_rs1_vld) || (id_rs2==ex_rd && id_rs2_vld)). Loads to x0 never stall.
- FSM states: IDLE and LU.
- IDLE: if lu_det && !ex_jmp_vld, then hold_if=1, load lu_cnt=LOAD_STALL-1, go to LU.
- LU with lu_cnt!=0: hold_if=1, decrement lu_cnt.
- LU with lu_cnt==0: hold_if from load-use is 0 and lu_det is masked, because ID/EX still shows the load. Return to IDLE.
- Total load-use hold is exactly LOAD_STALL cycles.
- ex_jmp_vld in any state: abort to IDLE, lu_cnt=0, and no load-use hold that cycle.
- ex_busy=1: hold_if=1 regardless of state. It is ORed with the load-use hold, and the FSM keeps advancing.
- Redirect (combinational), priority EX > ID > none:
  - ex_jmp_vld → jmp_vld_if=1, jmp_addr_if=ex_jmp_addr
  - else id_jmp_vld → jmp_vld_if=1, jmp_addr_if=id_pc+id_imm (XLEN-bit add, wraps mod 2^XLEN)
  - else jmp_vld_if=0, jmp_addr_if=0
- Flush counter fl_cnt:
  - on ex_jmp_vld, fl_cnt ← EX_FLUSH-1
  - else if fl_cnt!=0, fl_cnt ← fl_cnt-1
  - jmp_bub = ex_jmp_vld || fl_cnt!=0
- hold_bub = registered (load-use hold) from the previous cycle. ex_busy holds do not create bubbles, since the EX instruction stays in EX.
- inst_vld_ex = !(jmp_bub || hold_bub).
- Back-to-back ex_jmp_vld restarts fl_cnt; no accumulation.
- Performance counters:
  - stall_cnt += 1 on each cycle with hold_if=1
  - flush_cnt += 1 on each cycle with jmp_bub=1
  - both saturate at all-ones and never wrap

## Timing
- Reset (async on rst_n low): state IDLE, lu_cnt=0, fl_cnt=0, hold_bub=0, stall_cnt=0, flush_cnt=0.
- Outputs during and after reset with all inputs 0: hold_if=0, jmp_vld_if=0, jmp_addr_if=0, inst_vld_ex=1.
- hold_if, jmp_vld_if and jmp_addr_if are combinational from inputs and state, with zero latency.
- inst_vld_ex goes low in the same cycle as ex_jmp_vld and stays low EX_FLUSH cycles total.
- For a load-use hazard, inst_vld_ex goes low one cycle after each load-use hold cycle, giving LOAD_STALL bubbles.
- Counters update on the clock edge following the qualifying cycle.
- Reset asserted mid-stall or mid-flush clears everything immediately. The first post-reset cycle behaves as IDLE.

## Test plan
- LOAD_STALL=1: lw x5 in EX, ID reads x5 via rs1 → hold_if=1 for 1 cycle, then masked for 1 cycle; inst_vld_ex=0 one cycle later; stall_cnt=1.
- LOAD_STALL=3: same hazard → hold_if=1 for 3 consecutive cycles; inst_vld_ex low for 3 cycles delayed by one; stall_cnt=3. A load to rd=x0 → no stall.
- EX_FLUSH=2: ex_jmp_vld=1 with ex_jmp_addr=0x100, and id_jmp_vld=1 in the same cycle → jmp_addr_if=0x100; inst_vld_ex=0 for 2 cycles; flush_cnt=2.
- id_jmp_vld with id_pc=0xFFFFFFF0, id_imm=0x20 → jmp_addr_if=0x00000010; inst_vld_ex stays 1.
- lu_det asserted together with ex_jmp_vld, or in mid-LU → FSM returns to IDLE, no further hold. With ex_busy=1 for 4 cycles → hold_if=1 for 4 cycles, inst_vld_ex stays 1.
- Force stall_cnt near saturation with PERF_W=4 and hold for 20 cycles → stall_cnt=15. Drop rst_n mid-flush → all outputs return to their reset values asynchronously.
